if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the fetch PC and drives a req/ack instruction-memory port.

---
 rtl/if_fetch_unit.sv | 123 ++++++++++++
 tb/tb_if_fetch_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: fetch PC, imem req/ack port, one-entry skid, stale-response drop
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic        inst_valid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] drop_addr;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] pkt_inst;
    logic [31:0] pkt_pc;
    logic [31:0] pkt_pc4;
    logic        pkt_valid;
    logic [1:0]  unused_rpc_low;

    assign unused_rpc_low = redirect_pc[1:0];

    // DROP keeps the abandoned address on the bus until its ack retires it
    assign imem_req   = (state == REQ) || (state == DROP);
    assign imem_addr  = (state == DROP) ? drop_addr : fetch_pc;
    assign inst_out   = pkt_inst;
    assign pc_out     = pkt_pc;
    assign pc4_out    = pkt_pc4;
    assign inst_valid = pkt_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            skid_inst <= NOP_INST;
            skid_pc   <= 32'h0;
            pkt_inst  <= NOP_INST;
            pkt_pc    <= 32'h0;
            pkt_pc4   <= 32'h0;
            pkt_valid <= 1'b0;
        end else if (redirect) begin
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            pkt_inst  <= NOP_INST;
            pkt_pc    <= 32'h0;
            pkt_pc4   <= 32'h0;
            pkt_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
                state <= DROP;
                if (state == REQ)
                    drop_addr <= fetch_pc;
            end else begin
                state <= REQ;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (!stall) begin
                        pkt_inst  <= NOP_INST;
                        pkt_pc    <= 32'h0;
                        pkt_pc4   <= 32'h0;
                        pkt_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (!stall) begin
                            pkt_inst  <= imem_rdata;
                            pkt_pc    <= fetch_pc;
                            pkt_pc4   <= fetch_pc + 32'd4;
                            pkt_valid <= 1'b1;
                        end else begin
                            skid_inst <= imem_rdata;
                            skid_pc   <= fetch_pc;
                            state     <= HOLD;
                        end
                    end else if (!stall) begin
                        pkt_inst  <= NOP_INST;
                        pkt_pc    <= 32'h0;
                        pkt_pc4   <= 32'h0;
                        pkt_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pkt_inst  <= skid_inst;
                        pkt_pc    <= skid_pc;
                        pkt_pc4   <= skid_pc + 32'd4;
                        pkt_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                DROP: begin
                    if (imem_ack)
                        state <= REQ;
                    if (!stall) begin
                        pkt_inst  <= NOP_INST;
                        pkt_pc    <= 32'h0;
                        pkt_pc4   <= 32'h0;
                        pkt_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit against a queue-based fetch model
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        inst_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .pc_out(pc_out), .pc4_out(pc4_out), .inst_valid(inst_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Model: fetched-but-unconsumed words sit in a queue; an abandoned request is tracked as "dropping".
    bit          m_boot;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_stale;
    logic [63:0] m_q[$];
    bit          m_pv;
    logic [31:0] m_pinst;
    logic [31:0] m_ppc;

    function automatic bit m_req();
        return !m_boot && (m_drop || m_q.size() == 0);
    endfunction

    task automatic m_reset();
        m_boot = 1; m_drop = 0; m_pc = RESET_PC; m_stale = 0;
        m_q.delete(); m_pv = 0; m_pinst = NOP_INST; m_ppc = 0;
    endtask

    task automatic m_bubble();
        m_pv = 0; m_pinst = NOP_INST; m_ppc = 0;
    endtask

    task automatic m_step(input bit r_n, input bit st, input bit rd, input logic [31:0] rpc,
                          input bit ack, input logic [31:0] rdata);
        bit req;
        logic [63:0] e;
        req = m_req();
        if (!r_n) begin
            m_reset();
            return;
        end
        m_boot = 0;
        if (rd) begin
            if (req && !ack) begin
                if (!m_drop) m_stale = m_pc;
                m_drop = 1;
            end else begin
                m_drop = 0;
            end
            m_pc = rpc & 32'hFFFF_FFFC;
            m_q.delete();
            m_bubble();
            return;
        end
        if (req && ack) begin
            if (m_drop) m_drop = 0;
            else begin
                m_q.push_back({rdata, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        if (!st) begin
            if (m_q.size() != 0) begin
                e = m_q.pop_front();
                m_pv = 1; m_pinst = e[63:32]; m_ppc = e[31:0];
            end else begin
                m_bubble();
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_pc4;
        exp_pc4 = m_pv ? m_ppc + 32'd4 : 32'h0;
        check("inst_valid", {31'b0, inst_valid}, {31'b0, m_pv});
        check("inst_out", inst_out, m_pinst);
        check("pc_out", pc_out, m_ppc);
        check("pc4_out", pc4_out, exp_pc4);
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        if (m_req())
            check("imem_addr", imem_addr, m_drop ? m_stale : m_pc);
    endtask

    int unsigned max_wait [4] = '{0, 2, 1, 2};
    int unsigned stall_pct[4] = '{0, 0, 30, 35};
    int unsigned redir_pct[4] = '{0, 6, 6, 12};
    int unsigned rst_pct  [4] = '{0, 0, 1, 2};
    logic [31:0] far_pcs  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'h0000_0100, 32'hFFFF_FFFC};

    initial begin
        int unsigned wait_cnt;
        rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
        m_reset();
        wait_cnt = 0;
        @(negedge clk);
        @(posedge clk);
        for (int ph = 0; ph < 4; ph++) begin
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                if (!(ph == 0 && cyc == 0)) check_outputs();
                rst_n    = !(ph == 0 && cyc == 0) && ($urandom_range(0, 99) >= rst_pct[ph]);
                stall    = ($urandom_range(0, 99) < stall_pct[ph]);
                redirect = ($urandom_range(0, 99) < redir_pct[ph]);
                redirect_pc = ($urandom_range(0, 1) == 0) ? far_pcs[$urandom_range(0, 3)]
                                                          : $urandom_range(0, 255);
                imem_rdata = mem_word(imem_addr);
                if (imem_req) begin
                    imem_ack = (wait_cnt == 0);
                    if (wait_cnt == 0) wait_cnt = $urandom_range(0, max_wait[ph]);
                    else wait_cnt--;
                end else begin
                    imem_ack = ($urandom_range(0, 9) == 0);
                end
                if (!rst_n) wait_cnt = $urandom_range(0, max_wait[ph]);
                m_step(rst_n, stall, redirect, redirect_pc, imem_ack, imem_rdata);
                @(posedge clk);
            end
        end
        @(negedge clk);
        check_outputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
